// File: rtl/psram_qpi_device_if.sv
// QPI PSRAM link between the controller (master) and the device (slave).
//   sck   : serial clock from the controller
//   ce_n  : chip enable, active low
//   dq_i  : controller -> device nibble
//   dq_o  : device -> controller nibble
//   dq_oe : device is driving dq_o
interface psram_qpi_device_if;
  logic       sck;
  logic       ce_n;
  logic [3:0] dq_i;
  logic [3:0] dq_o;
  logic       dq_oe;

  modport master (output sck, ce_n, dq_i, input dq_o, dq_oe);
  modport slave  (input sck, ce_n, dq_i, output dq_o, dq_oe);
endinterface

// File: rtl/psram_qpi_device.sv
// QPI pseudo-SRAM device model, oversampling sck/ce_n/dq_i in the clk domain.
// Decodes Enter-QPI (0x35), Exit-QPI (0xF5), quad read (0xEB) and quad write
// (0x38) against an internal byte array. A backdoor byte port allows preload
// and inspection while the chip is deselected.
//   clk, rst_n : system clock, async active-low reset
//   bus        : QPI link (slave modport)
//   qpi_mode   : 1 after Enter-QPI
//   bd_*       : backdoor write strobe/address/data, combinational read data
// ADDR_W is expected to be <= 24 (address bits above ADDR_W are dropped).
module psram_qpi_device #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  psram_qpi_device_if.slave bus,
  output logic              qpi_mode,
  input  logic              bd_we,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [7:0]        bd_wdata,
  output logic [7:0]        bd_rdata
);

  typedef enum logic [2:0] {CMD, ADDR, WAIT, RDATA, WDATA, IGNORE} state_t;

  localparam logic [7:0] WLAST = 8'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t            state, state_n;
  logic [2:0]        sck_pipe;       // [0],[1] synchronizer, [2] edge history
  logic [1:0]        ce_pipe;
  logic [1:0][3:0]   dq_pipe;
  logic              rise, fall, ce_s;
  logic [3:0]        dq_s;
  logic [7:0]        cnt;
  logic [7:0]        cmd, cmd_nxt;
  logic              cmd_done;
  logic              rd;             // latched: current command is 0xEB
  logic              phase;          // 0 = high nibble next, 1 = low nibble next
  logic [3:0]        hi;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic [7:0]        mem_rd;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_pipe <= '0;
      ce_pipe  <= '1;
      dq_pipe  <= '0;
    end else begin
      sck_pipe <= {sck_pipe[1:0], bus.sck};
      ce_pipe  <= {ce_pipe[0], bus.ce_n};
      dq_pipe  <= {dq_pipe[0], bus.dq_i};
    end
  end

  assign rise = sck_pipe[1] & ~sck_pipe[2];
  assign fall = ~sck_pipe[1] & sck_pipe[2];
  assign ce_s = ce_pipe[1];
  assign dq_s = dq_pipe[1];

  // Serial mode shifts one bit on dq[0]; QPI shifts a nibble.
  assign cmd_nxt  = qpi_mode ? {cmd[3:0], dq_s} : {cmd[6:0], dq_s[0]};
  assign cmd_done = (cnt == (qpi_mode ? 8'd1 : 8'd7));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CMD;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (ce_s) state_n = CMD;
    else if (rise) begin
      case (state)
        CMD:  if (cmd_done)
                state_n = (cmd_nxt == 8'hEB || cmd_nxt == 8'h38) ? ADDR : IGNORE;
        ADDR: if (cnt == 8'd5)
                state_n = !rd ? WDATA : (WAIT_CYCLES == 0) ? RDATA : WAIT;
        WAIT: if (cnt == WLAST) state_n = RDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      cmd      <= '0;
      rd       <= 1'b0;
      phase    <= 1'b0;
      hi       <= '0;
      addr     <= '0;
      qpi_mode <= 1'b0;
      bus.dq_o  <= '0;
      bus.dq_oe <= 1'b0;
    end else if (ce_s) begin
      cnt       <= '0;
      phase     <= 1'b0;
      bus.dq_oe <= 1'b0;
    end else begin
      if (rise) begin
        case (state)
          CMD: begin
            cmd <= cmd_nxt;
            cnt <= cmd_done ? 8'd0 : cnt + 8'd1;
            if (cmd_done) begin
              rd <= (cmd_nxt == 8'hEB);
              if (!qpi_mode && cmd_nxt == 8'h35) qpi_mode <= 1'b1;
              if (qpi_mode && cmd_nxt == 8'hF5)  qpi_mode <= 1'b0;
            end
          end
          ADDR: begin
            // Only the low ADDR_W bits of the 24-bit address survive.
            addr <= ADDR_W'({addr, dq_s});
            cnt  <= (cnt == 8'd5) ? 8'd0 : cnt + 8'd1;
          end
          WAIT: cnt <= cnt + 8'd1;
          WDATA: begin
            phase <= ~phase;
            if (!phase) hi <= dq_s;
            else        addr <= addr + 1'b1;
          end
          default: ;
        endcase
      end
      if (fall && state == RDATA) begin
        bus.dq_oe <= 1'b1;
        bus.dq_o  <= phase ? mem_rd[3:0] : mem_rd[7:4];
        phase     <= ~phase;
        if (phase) addr <= addr + 1'b1;
      end
    end
  end

  // Device writes only happen with ce_n low, backdoor only with ce_n high.
  assign wr_en  = !ce_s && rise && state == WDATA && phase;
  assign mem_rd = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en)              mem[addr]    <= {hi, dq_s};
    else if (bd_we && ce_s) mem[bd_addr] <= bd_wdata;
  end

  assign bd_rdata = mem[bd_addr];

endmodule

// File: tb/tb_psram_qpi_device.sv
// Directed + randomized bench for psram_qpi_device. A byte-array reference
// model tracks every write; reads are predicted from it with wrap arithmetic.
module tb_psram_qpi_device;
  localparam int AW  = 12;
  localparam int WC  = 6;
  localparam int HP  = 4;          // sck half period in clk cycles
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          qpi_mode;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [7:0]    bd_wdata, bd_rdata;

  always #5 clk = ~clk;

  psram_qpi_device_if bus();

  psram_qpi_device #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .qpi_mode (qpi_mode),
    .bd_we    (bd_we),
    .bd_addr  (bd_addr),
    .bd_wdata (bd_wdata),
    .bd_rdata (bd_rdata)
  );

  logic [7:0] ref_mem [MSZ];
  logic       ref_qpi;
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] d);
    bus.dq_i = d;
    wait_clk(HP);
    bus.sck = 1'b1;
    wait_clk(HP);
    bus.sck = 1'b0;
  endtask

  task automatic rd_nib(output logic [3:0] v, output logic oe);
    wait_clk(HP);
    v  = bus.dq_o;
    oe = bus.dq_oe;
    bus.sck = 1'b1;
    wait_clk(HP);
    bus.sck = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    if (ref_qpi) begin
      pulse(c[7:4]);
      pulse(c[3:0]);
    end else
      for (int i = 7; i >= 0; i--) pulse({3'b000, c[i]});
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) pulse(a[i*4 +: 4]);
  endtask

  task automatic cs_lo();
    bus.ce_n = 1'b0;
    wait_clk(HP);
  endtask

  task automatic cs_hi();
    wait_clk(HP);
    bus.ce_n = 1'b1;
    wait_clk(HP);
  endtask

  task automatic bd_wr(input int a, input logic [7:0] d);
    bd_addr  = AW'(a);
    bd_wdata = d;
    bd_we    = 1'b1;
    wait_clk(1);
    bd_we    = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic bd_chk(input string tag, input int a);
    bd_addr = AW'(a);
    #1;
    check(tag, 32'(bd_rdata), 32'(ref_mem[a]));
  endtask

  // Quad write burst; the model commits each byte at (a + i) mod array size.
  task automatic do_write(input logic [23:0] a, input logic [7:0] data [$]);
    cs_lo();
    send_cmd(8'h38);
    send_addr(a);
    foreach (data[i]) begin
      pulse(data[i][7:4]);
      pulse(data[i][3:0]);
      ref_mem[(int'(a) + i) % MSZ] = data[i];
    end
    cs_hi();
  endtask

  task automatic do_read(input string tag, input logic [23:0] a, input int n);
    logic [3:0] v;
    logic       oe;
    logic [7:0] b;
    cs_lo();
    send_cmd(8'hEB);
    send_addr(a);
    repeat (WC) pulse(4'h0);
    for (int i = 0; i < 2 * n; i++) begin
      rd_nib(v, oe);
      b = ref_mem[(int'(a) + i / 2) % MSZ];
      check({tag, "_nib"}, 32'(v), 32'((i % 2 == 0) ? b[7:4] : b[3:0]));
      check({tag, "_oe"}, 32'(oe), 32'd1);
    end
    cs_hi();
    check({tag, "_oe_off"}, 32'(bus.dq_oe), 32'd0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] q [$];
    logic [7:0] saved;
    logic [3:0] v;
    logic       oe;
    logic [23:0] ra;
    int         n;

    bus.sck = 1'b0; bus.ce_n = 1'b1; bus.dq_i = '0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    ref_qpi = 1'b0;
    wait_clk(3);
    check("rst_dq_o", 32'(bus.dq_o), 32'd0);
    check("rst_dq_oe", 32'(bus.dq_oe), 32'd0);
    check("rst_qpi", 32'(qpi_mode), 32'd0);
    rst_n = 1'b1;
    wait_clk(3);

    for (int i = 0; i < MSZ; i++) bd_wr(i, 8'($urandom));
    bd_chk("preload_0", 0);
    bd_chk("preload_mid", 1234);
    bd_chk("preload_top", MSZ - 1);

    // Enter QPI over the serial path.
    cs_lo();
    send_cmd(8'h35);
    check("enter_qpi", 32'(qpi_mode), 32'd1);
    check("enter_oe", 32'(bus.dq_oe), 32'd0);
    cs_hi();
    ref_qpi = 1'b1;

    q = '{8'hA5, 8'h3C};
    do_write(24'h000010, q);
    bd_chk("wr_10", 'h10);
    bd_chk("wr_11", 'h11);

    bd_wr('h20, 8'h11); bd_wr('h21, 8'h22); bd_wr('h22, 8'h33); bd_wr('h23, 8'h44);
    do_read("rd_20", 24'h000020, 4);

    // Wrap at the top of the array.
    q = '{8'($urandom), 8'($urandom)};
    do_write(24'h000FFF, q);
    bd_chk("wrap_fff", 'hFFF);
    bd_chk("wrap_000", 0);
    do_read("rd_wrap", 24'h000FFF, 2);

    // Trailing lone high nibble is dropped.
    cs_lo();
    send_cmd(8'h38);
    send_addr(24'h000040);
    pulse(4'h7); pulse(4'hE); pulse(4'h9);
    cs_hi();
    ref_mem['h40] = 8'h7E;
    bd_chk("part_40", 'h40);
    bd_chk("part_41", 'h41);

    // 0x35 in QPI and an unknown opcode are both ignored.
    cs_lo();
    send_cmd(8'h35);
    cs_hi();
    check("qpi_35_ignored", 32'(qpi_mode), 32'd1);
    cs_lo();
    send_cmd(8'h5A);
    send_addr(24'h000050);
    pulse(4'h1); pulse(4'h2);
    cs_hi();
    bd_chk("unknown_50", 'h50);
    check("unknown_oe", 32'(bus.dq_oe), 32'd0);

    // Deselect mid-address, then a full transaction must still decode.
    cs_lo();
    send_cmd(8'h38);
    pulse(4'h0); pulse(4'h0); pulse(4'h0);
    cs_hi();
    q = '{8'h5C};
    do_write(24'h000060, q);
    bd_chk("after_abort_60", 'h60);

    // Random bursts with random upper address bits.
    for (int k = 0; k < 6; k++) begin
      ra = 24'($urandom);
      n  = $urandom_range(1, 5);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      do_write(ra, q);
      do_read($sformatf("rnd%0d", k), ra, n);
      bd_chk($sformatf("rnd%0d_bd", k), int'(ra) % MSZ);
    end

    // Exit QPI, then run a read and a write with serial commands.
    send_cmd(8'h00);
    cs_lo();
    send_cmd(8'hF5);
    cs_hi();
    check("exit_qpi", 32'(qpi_mode), 32'd0);
    ref_qpi = 1'b0;
    q = '{8'h96, 8'h69};
    do_write(24'h000300, q);
    do_read("serial_rd", 24'h0002FF, 4);

    // Reset during a read burst.
    cs_lo();
    send_cmd(8'h35);
    cs_hi();
    ref_qpi = 1'b1;
    saved = ref_mem['h300];
    cs_lo();
    send_cmd(8'hEB);
    send_addr(24'h000300);
    repeat (WC) pulse(4'h0);
    rd_nib(v, oe);
    rd_nib(v, oe);
    wait_clk(HP);
    check("pre_rst_oe", 32'(bus.dq_oe), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_oe", 32'(bus.dq_oe), 32'd0);
    check("rst_mid_qpi", 32'(qpi_mode), 32'd0);
    bus.sck = 1'b0;
    bus.ce_n = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    ref_qpi = 1'b0;
    wait_clk(3);
    check("rst_mem_kept", 32'(ref_mem['h300]), 32'(saved));
    bd_chk("rst_mem_300", 'h300);
    cs_lo();
    send_cmd(8'h35);
    cs_hi();
    check("reenter_qpi", 32'(qpi_mode), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
